// File: rtl/alarm_ringer_pkg.sv
// Shared types and widths for the alarm ringer slice.
package alarm_ringer_pkg;

   localparam int TIME_W = 6;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      RING   = 2'b01,
      SNOOZE = 2'b10
   } state_e;

endpackage

// File: rtl/alarm_ringer_if.sv
// Signal bundle between the watch/alarm-setting logic and the ringer.
interface alarm_ringer_if;
   import alarm_ringer_pkg::*;

   // tick_1hz, snooze and aclear are single-clk pulses; everything else is a level.
   logic              tick_1hz;
   logic [TIME_W-1:0] cur_hour;
   logic [TIME_W-1:0] cur_min;
   logic [TIME_W-1:0] cur_sec;
   logic [TIME_W-1:0] al_hour;
   logic [TIME_W-1:0] al_min;
   logic              al_en;
   logic              in_edit;
   logic              snooze;
   logic              aclear;
   logic              buzz;
   logic              ringing;
   logic              snoozed;
   logic [1:0]        RS;

   modport master (
      output tick_1hz, cur_hour, cur_min, cur_sec, al_hour, al_min,
             al_en, in_edit, snooze, aclear,
      input  buzz, ringing, snoozed, RS
   );

   modport slave (
      input  tick_1hz, cur_hour, cur_min, cur_sec, al_hour, al_min,
             al_en, in_edit, snooze, aclear,
      output buzz, ringing, snoozed, RS
   );

endinterface

// File: rtl/alarm_ringer_sec_down_counter.sv
// Loadable seconds down-counter that stops at zero; clr has priority over load.
module alarm_ringer_sec_down_counter #(
   parameter int W = 6
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clr,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         tick_en,
   output logic [W-1:0] cnt,
   output logic         zero
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (load) begin
         cnt_d = load_val;
      end else if (tick_en && (cnt_q != '0)) begin
         cnt_d = cnt_q - W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt  = cnt_q;
   assign zero = (cnt_q == '0);

endmodule

// File: rtl/alarm_ringer.sv
// Alarm ringer: edge-detects the alarm-time match, rings with a toggling buzzer,
// supports bounded snoozes, auto-timeout and clear.
module alarm_ringer
   import alarm_ringer_pkg::*;
#(
   parameter int RING_SECS   = 60,
   parameter int SNOOZE_SECS = 300,
   parameter int MAX_SNOOZE  = 3
) (
   input  logic           clk,
   input  logic           reset,
   alarm_ringer_if.slave  bus
);

   localparam int RING_W = $clog2(RING_SECS + 1);
   localparam int SNZ_W  = $clog2(SNOOZE_SECS + 1);
   localparam int USED_W = $clog2(MAX_SNOOZE + 1);

   state_e            state_q, state_d;
   logic              beep_q, beep_d;
   logic [USED_W-1:0] snz_used_q, snz_used_d;
   logic              match_prev_q, match_prev_d;

   logic              match, trigger, clear, snz_ok;
   logic              ring_load, ring_tick, snz_load, snz_tick;
   logic [RING_W-1:0] ring_cnt;
   logic [SNZ_W-1:0]  snz_cnt;
   logic              ring_zero, snz_zero, ring_last, snz_last;

   assign match = bus.al_en & ~bus.in_edit &
                  (bus.cur_hour == bus.al_hour) & (bus.cur_min == bus.al_min) &
                  (bus.cur_sec == '0);
   assign trigger = match & ~match_prev_q;
   assign clear   = ~bus.al_en | bus.aclear;
   assign snz_ok  = bus.snooze & (snz_used_q < USED_W'(MAX_SNOOZE));

   // "last" means the next tick brings the count to zero, so the state moves on that tick.
   assign ring_last = ring_zero | (ring_cnt == RING_W'(1));
   assign snz_last  = snz_zero | (snz_cnt == SNZ_W'(1));

   always_comb begin
      state_d      = state_q;
      beep_d       = beep_q;
      snz_used_d   = snz_used_q;
      match_prev_d = match;
      ring_load    = 1'b0;
      ring_tick    = 1'b0;
      snz_load     = 1'b0;
      snz_tick     = 1'b0;
      if (clear) begin
         state_d    = IDLE;
         beep_d     = 1'b0;
         snz_used_d = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (trigger) begin
                  state_d    = RING;
                  ring_load  = 1'b1;
                  snz_used_d = '0;
                  beep_d     = 1'b1;
               end
            end
            RING: begin
               if (snz_ok) begin
                  state_d    = SNOOZE;
                  snz_load   = 1'b1;
                  snz_used_d = snz_used_q + USED_W'(1);
                  beep_d     = 1'b0;
               end else if (bus.tick_1hz) begin
                  ring_tick = 1'b1;
                  beep_d    = ~beep_q;
                  if (ring_last) begin
                     state_d = IDLE;
                     beep_d  = 1'b0;
                  end
               end
            end
            SNOOZE: begin
               if (bus.tick_1hz) begin
                  snz_tick = 1'b1;
                  if (snz_last) begin
                     state_d   = RING;
                     ring_load = 1'b1;
                     beep_d    = 1'b1;
                  end
               end
            end
            default: begin
               state_d = IDLE;
               beep_d  = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= IDLE;
         beep_q       <= 1'b0;
         snz_used_q   <= '0;
         match_prev_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         beep_q       <= beep_d;
         snz_used_q   <= snz_used_d;
         match_prev_q <= match_prev_d;
      end
   end

   alarm_ringer_sec_down_counter #(.W(RING_W)) u_ring_cnt (
      .clk      (clk),
      .reset    (reset),
      .clr      (clear),
      .load     (ring_load),
      .load_val (RING_W'(RING_SECS)),
      .tick_en  (ring_tick),
      .cnt      (ring_cnt),
      .zero     (ring_zero)
   );

   alarm_ringer_sec_down_counter #(.W(SNZ_W)) u_snz_cnt (
      .clk      (clk),
      .reset    (reset),
      .clr      (clear),
      .load     (snz_load),
      .load_val (SNZ_W'(SNOOZE_SECS)),
      .tick_en  (snz_tick),
      .cnt      (snz_cnt),
      .zero     (snz_zero)
   );

   assign bus.buzz    = (state_q == RING) & beep_q;
   assign bus.ringing = (state_q == RING);
   assign bus.snoozed = (state_q == SNOOZE);
   assign bus.RS      = state_q;

endmodule

// File: tb/tb_alarm_ringer.sv
// Scripted bench for alarm_ringer with an expected-output queue per driven cycle.
module tb_alarm_ringer;
   import alarm_ringer_pkg::*;

   // Expected word layout: {buzz, ringing, snoozed, RS[1:0]}
   localparam logic [4:0] E_IDLE = 5'b00000;
   localparam logic [4:0] E_ON   = 5'b11001;
   localparam logic [4:0] E_OFF  = 5'b01001;
   localparam logic [4:0] E_SNZ  = 5'b00110;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   alarm_ringer_if bus ();

   alarm_ringer #(
      .RING_SECS   (4),
      .SNOOZE_SECS (5),
      .MAX_SNOOZE  (2)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int          n_checks = 0;
   int          n_errors = 0;
   logic [4:0]  exp_q[$];
   string       tag_q[$];

   task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %b expected %b (buzz,ringing,snoozed,RS)", tag, obs, exp);
      end
   endtask

   task automatic set_time(input int h, input int m, input int s);
      bus.cur_hour = 6'(h);
      bus.cur_min  = 6'(m);
      bus.cur_sec  = 6'(s);
   endtask

   // Drive one clock with the given pulses, then compare the outputs of that edge.
   task automatic cyc(input logic tick, input logic snz, input logic clr,
                      input logic [4:0] exp, input string tag);
      bus.tick_1hz = tick;
      bus.snooze   = snz;
      bus.aclear   = clr;
      exp_q.push_back(exp);
      tag_q.push_back(tag);
      @(posedge clk);
      #1;
      bus.tick_1hz = 1'b0;
      bus.snooze   = 1'b0;
      bus.aclear   = 1'b0;
      check(tag_q.pop_front(), {bus.buzz, bus.ringing, bus.snoozed, bus.RS}, exp_q.pop_front());
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.tick_1hz = 1'b0;
      bus.snooze   = 1'b0;
      bus.aclear   = 1'b0;
      bus.al_en    = 1'b1;
      bus.in_edit  = 1'b0;
      bus.al_hour  = 6'd7;
      bus.al_min   = 6'd30;
      set_time(7, 29, 59);
      reset = 1'b0;
      cyc(0, 0, 0, E_IDLE, "reset_a");
      cyc(0, 0, 0, E_IDLE, "reset_b");
      reset = 1'b1;
      cyc(0, 0, 0, E_IDLE, "idle_pre");

      // Basic trigger and auto-off after four ticks
      set_time(7, 30, 0);
      cyc(0, 0, 0, E_ON,   "trigger");
      cyc(0, 0, 0, E_ON,   "hold_no_tick");
      cyc(1, 0, 0, E_OFF,  "tick1");
      cyc(1, 0, 0, E_ON,   "tick2");
      cyc(1, 0, 0, E_OFF,  "tick3");
      cyc(1, 0, 0, E_IDLE, "auto_off");
      for (int i = 0; i < 10; i++) cyc(1, 0, 0, E_IDLE, "no_retrigger");

      // in_edit masks a match
      set_time(7, 29, 59);
      cyc(0, 0, 0, E_IDLE, "edit_pre");
      bus.in_edit = 1'b1;
      set_time(7, 30, 0);
      cyc(0, 0, 0, E_IDLE, "edit_mask");
      cyc(1, 0, 0, E_IDLE, "edit_mask_hold");
      set_time(7, 30, 1);
      cyc(0, 0, 0, E_IDLE, "edit_move");
      bus.in_edit = 1'b0;
      cyc(0, 0, 0, E_IDLE, "edit_release");

      // Snooze cycle up to the snooze limit
      set_time(7, 29, 59);
      cyc(0, 0, 0, E_IDLE, "snz_pre");
      set_time(7, 30, 0);
      cyc(0, 0, 0, E_ON,  "trigger2");
      cyc(0, 1, 0, E_SNZ, "snooze1");
      for (int i = 0; i < 4; i++) cyc(1, 0, 0, E_SNZ, "snz1_count");
      cyc(1, 0, 0, E_ON,  "rering1");
      cyc(0, 1, 0, E_SNZ, "snooze2");
      for (int i = 0; i < 4; i++) cyc(1, 0, 0, E_SNZ, "snz2_count");
      cyc(1, 0, 0, E_ON,  "rering2");
      cyc(0, 1, 0, E_ON,  "snooze3_ignored");
      cyc(1, 1, 0, E_OFF, "snooze3_tick");
      cyc(1, 0, 0, E_ON,  "ring_after_limit");
      cyc(0, 1, 1, E_IDLE, "snooze_aclear");
      cyc(0, 0, 0, E_IDLE, "clear_hold");

      // Snooze coinciding with a tick loads the full snooze time
      set_time(7, 29, 59);
      cyc(0, 0, 0, E_IDLE, "st_pre");
      set_time(7, 30, 0);
      cyc(0, 0, 0, E_ON,  "trigger3");
      cyc(1, 1, 0, E_SNZ, "snooze_tick");
      for (int i = 0; i < 4; i++) cyc(1, 0, 0, E_SNZ, "snz_full_load");
      cyc(1, 0, 0, E_ON,  "rering3");
      cyc(0, 1, 0, E_SNZ, "snooze4");
      cyc(1, 0, 0, E_SNZ, "snz4_count");
      bus.al_en = 1'b0;
      cyc(0, 0, 0, E_IDLE, "al_en_drop");
      set_time(7, 29, 59);
      bus.al_en = 1'b1;
      cyc(0, 0, 0, E_IDLE, "al_en_restore");

      // aclear while snoozed
      set_time(7, 30, 0);
      cyc(0, 0, 0, E_ON,   "trigger4");
      cyc(0, 1, 0, E_SNZ,  "snooze5");
      cyc(0, 0, 1, E_IDLE, "aclear_snz");

      // Reset mid-ring, re-trigger after release, no restart, in_edit mid-ring
      set_time(7, 29, 59);
      cyc(0, 0, 0, E_IDLE, "rst_pre");
      set_time(7, 30, 0);
      cyc(0, 0, 0, E_ON,  "trigger5");
      cyc(1, 0, 0, E_OFF, "trigger5_tick");
      reset = 1'b0;
      cyc(1, 0, 0, E_IDLE, "reset_mid");
      reset = 1'b1;
      cyc(0, 0, 0, E_ON,  "retrigger_after_reset");
      cyc(1, 0, 0, E_OFF, "rt_tick1");
      set_time(7, 30, 1);
      cyc(0, 0, 0, E_OFF, "rt_move");
      set_time(7, 30, 0);
      cyc(0, 0, 0, E_OFF, "no_restart");
      bus.in_edit = 1'b1;
      cyc(1, 0, 0, E_ON,   "edit_mid_ring");
      cyc(1, 0, 0, E_OFF,  "rt_tick3");
      cyc(1, 0, 0, E_IDLE, "auto_off2");
      set_time(7, 29, 59);
      bus.in_edit = 1'b0;
      for (int i = 0; i < 3; i++) cyc(1, 0, 0, E_IDLE, "final_idle");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/alarm_ringer.md
Name: alarm_ringer

Overview:
Downstream consumer of the alarm-setting block's hour/min outputs. Compares the stored alarm time against the running watch time and raises the buzzer. Handles auto-timeout, snooze with a bounded repeat count, and clear. Output drives the buzzer/LED pin and a state code for the display mux.

Parameters:
RING_SECS, 60, seconds of ringing before auto-off
SNOOZE_SECS, 300, seconds of silence after a snooze before re-ringing
MAX_SNOOZE, 3, snoozes accepted per alarm event; further snooze presses are ignored

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
tick_1hz  in  1  one-clk pulse per second from the timekeeper
cur_hour  in  6  watch time hour, 0..23
cur_min  in  6  watch time minute, 0..59
cur_sec  in  6  watch time second, 0..59
al_hour  in  6  alarm hour, 0..23
al_min  in  6  alarm minute, 0..59
al_en  in  1  alarm armed (level)
in_edit  in  1  alarm block is in an edit state; matching is suppressed
snooze  in  1  one-clk pulse (debounced button)
aclear  in  1  one-clk pulse (debounced button)
buzz  out  1  buzzer drive
ringing  out  1  high in RING
snoozed  out  1  high in SNOOZE
RS  out  2  state code: IDLE=00, RING=01, SNOOZE=10

Behaviour:
- Reset (reset==0 at posedge clk): state IDLE; buzz, ringing, snoozed = 0; all counters 0; match_prev = 0.
- match = al_en & ~in_edit & (cur_hour==al_hour) & (cur_min==al_min) & (cur_sec==0). Combinational; registered into match_prev every clk.
- Trigger = match & ~match_prev (rising edge). Fires once per event. Holding the matched time does not retrigger.
- IDLE: on trigger -> RING. Load ring_cnt=RING_SECS, snz_used=0, beep=1.
- RING:
  - buzz = beep. beep toggles on each tick_1hz.
  - ring_cnt decrements on tick_1hz. Reaching 0 -> IDLE, same cycle as the tick that makes it 0.
  - On snooze with snz_used<MAX_SNOOZE -> SNOOZE. Load snz_cnt=SNOOZE_SECS; snz_used+=1; buzz=0.
  - On snooze with snz_used==MAX_SNOOZE: ignored, keeps ringing.
- SNOOZE:
  - buzz=0. snz_cnt decrements on tick_1hz.
  - At 0 -> RING. Reload ring_cnt=RING_SECS, beep=1. snz_used is kept.
- Any state: aclear -> IDLE. al_en==0 -> IDLE. Outputs are 0 from the next cycle.
- Priority in one cycle: reset > al_en==0 > aclear > snooze > tick_1hz countdown > trigger.
- Snooze and tick in the same cycle: snooze wins. snz_cnt loads the full SNOOZE_SECS with no decrement.
- A trigger in RING or SNOOZE is ignored (no restart).
- Registered outputs, 1-clk latency from the causing input edge. ringing/snoozed/RS decode from the state register.
- Counter widths: $clog2(max+1). Decrement never wraps below 0.
- in_edit rising mid-RING does not stop the ring. It only masks new triggers.

Decomposition:
- Shared package holds the state encodings IDLE/RING/SNOOZE (2-bit) and the hour/min width constant (6).
- One natural sub-module: sec_down_counter (load value, tick enable, zero flag), instantiated twice, for ring_cnt and snz_cnt.

Test Plan:
Benches override RING_SECS=4, SNOOZE_SECS=5, MAX_SNOOZE=2.
- Basic trigger: al_en=1, al=07:30; drive cur from 07:29:59 to 07:30:00 -> RING the next clk, buzz=1; buzz toggles each tick; IDLE after the 4th tick; buzz=0.
- No retrigger: hold cur=07:30:00 for 10 ticks after the auto-off -> stays IDLE. Also in_edit=1 at 07:30:00 -> no trigger.
- Snooze cycle: snooze in RING -> SNOOZE, buzz=0; after 5 ticks -> RING; second snooze -> SNOOZE; after 5 ticks -> RING; third snooze ignored, buzz keeps toggling.
- Clear priority: snooze and aclear in the same clk during RING -> IDLE, snoozed=0. al_en dropped during SNOOZE -> IDLE the next clk.
- Same-cycle snooze+tick: snooze coincides with tick_1hz -> snz_cnt=5, not 4; RING re-entered exactly 5 ticks later.
- Reset mid-RING: reset=0 for one clk -> IDLE, buzz=0, counters 0. After release with cur still 07:30:00: match_prev clears to 0 on reset, so RING re-triggers once.
